// File: rtl/decode_trace_buffer.sv
// Decode-stage trace capture: circular buffer of decoded instructions, frozen after a
// post-trigger window and drained oldest-first over a show-ahead valid/ready port.
module decode_trace_buffer #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned IMM_W     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8,
  parameter int unsigned TRIG_MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  arm,
  input  logic                                  abort,
  input  logic [PC_W-1:0]                       trig_pc,
  input  logic                                  cap_valid,
  input  logic [PC_W-1:0]                       cap_pc,
  input  logic [6:0]                            cap_opcode,
  input  logic [REG_AW-1:0]                     cap_rd,
  input  logic [REG_AW-1:0]                     cap_rs1,
  input  logic [REG_AW-1:0]                     cap_rs2,
  input  logic [IMM_W-1:0]                      cap_imm,
  input  logic                                  cap_reg_write,
  input  logic                                  cap_alu_src,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic [PC_W+7+3*REG_AW+IMM_W+2-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]                count,
  output logic [1:0]                            state,
  output logic                                  wrapped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + 7 + 3 * REG_AW + IMM_W + 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StPost  = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d, wr_addr;
  logic [CW-1:0]   count_q, count_d, post_q, post_d;
  logic            wrapped_q, wrapped_d;
  logic            wr_en;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   mem [DEPTH];

  assign entry = {cap_pc, cap_opcode, cap_rd, cap_rs1, cap_rs2, cap_imm, cap_reg_write,
                  cap_alu_src};

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    post_d    = post_q;
    wrapped_d = wrapped_q;
    wr_en     = 1'b0;
    wr_addr   = tail_q;
    if (abort) begin
      state_d = StIdle;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      post_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            if (TRIG_MODE == 1) begin
              // The arm cycle itself is the trigger; a capture here is the trigger entry.
              post_d  = CW'(POST_TRIG);
              state_d = StPost;
              if (cap_valid) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                tail_d  = AW'(1);
                count_d = CW'(1);
                if (POST_TRIG == 0) state_d = StDone;
              end
            end else begin
              state_d = StArmed;
            end
          end
        end
        StArmed, StPost: begin
          if (cap_valid) begin
            wr_en  = 1'b1;
            tail_d = tail_q + 1'b1;
            if (count_q == CW'(DEPTH)) begin
              head_d    = head_q + 1'b1;
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
            if (state_q == StArmed) begin
              if (TRIG_MODE == 0 && cap_pc == trig_pc) begin
                post_d  = CW'(POST_TRIG);
                state_d = (POST_TRIG == 0) ? StDone : StPost;
              end
            end else if (post_q <= CW'(1)) begin
              post_d  = '0;
              state_d = StDone;
            end else begin
              post_d = post_q - 1'b1;
            end
          end
        end
        StDone: begin
          if (count_q == '0) begin
            state_d = StIdle;
          end else if (rd_ready) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      post_q    <= post_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Storage needs no reset: rd_data is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_addr] <= entry;
  end

  assign rd_valid = (state_q == StDone) && (count_q != '0);
  assign rd_data  = rd_valid ? mem[head_q] : '0;
  assign count    = count_q;
  assign state    = state_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_decode_trace_buffer.sv
// Bench for decode_trace_buffer: two configurations checked against a queue-based model,
// directed scenarios followed by random traffic.
module tb_decode_trace_buffer;

  localparam int EW = 32 + 7 + 15 + 32 + 2;
  localparam int D0_DEPTH = 16, D0_POST = 8, D0_MODE = 0;
  localparam int D1_DEPTH = 8,  D1_POST = 3, D1_MODE = 1;

  typedef logic [EW-1:0] ent_t;

  logic        clk = 1'b0;
  logic        reset, arm0, arm1, abort, cap_valid, cap_reg_write, cap_alu_src, rd_ready;
  logic [31:0] trig_pc, cap_pc, cap_imm;
  logic [6:0]  cap_opcode;
  logic [4:0]  cap_rd, cap_rs1, cap_rs2;

  logic        rd_valid0, rd_valid1, wrapped0, wrapped1;
  ent_t        rd_data0, rd_data1;
  logic [4:0]  count0;
  logic [3:0]  count1;
  logic [1:0]  state0, state1;

  bit          sel;
  int          total = 0, bad = 0;

  // model state: 0 idle, 1 armed, 2 post, 3 done
  int          m_state, m_left;
  bit          m_wrap;
  ent_t        mq[$];

  always #5 clk = ~clk;

  decode_trace_buffer #(.PC_W(32), .REG_AW(5), .IMM_W(32), .DEPTH(D0_DEPTH),
                        .POST_TRIG(D0_POST), .TRIG_MODE(D0_MODE)) dut0 (
    .clk(clk), .reset(reset), .arm(arm0), .abort(abort), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_opcode(cap_opcode), .cap_rd(cap_rd),
    .cap_rs1(cap_rs1), .cap_rs2(cap_rs2), .cap_imm(cap_imm), .cap_reg_write(cap_reg_write),
    .cap_alu_src(cap_alu_src), .rd_valid(rd_valid0), .rd_ready(rd_ready),
    .rd_data(rd_data0), .count(count0), .state(state0), .wrapped(wrapped0));

  decode_trace_buffer #(.PC_W(32), .REG_AW(5), .IMM_W(32), .DEPTH(D1_DEPTH),
                        .POST_TRIG(D1_POST), .TRIG_MODE(D1_MODE)) dut1 (
    .clk(clk), .reset(reset), .arm(arm1), .abort(abort), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_opcode(cap_opcode), .cap_rd(cap_rd),
    .cap_rs1(cap_rs1), .cap_rs2(cap_rs2), .cap_imm(cap_imm), .cap_reg_write(cap_reg_write),
    .cap_alu_src(cap_alu_src), .rd_valid(rd_valid1), .rd_ready(rd_ready),
    .rd_data(rd_data1), .count(count1), .state(state1), .wrapped(wrapped1));

  wire [1:0]  obs_state   = sel ? state1 : state0;
  wire [4:0]  obs_count   = sel ? {1'b0, count1} : count0;
  wire        obs_wrapped = sel ? wrapped1 : wrapped0;
  wire        obs_valid   = sel ? rd_valid1 : rd_valid0;
  wire [EW-1:0] obs_data  = sel ? rd_data1 : rd_data0;
  wire [31:0] obs_pc      = obs_data[87:56];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input ent_t e, input int dep);
    mq.push_back(e);
    if (mq.size() > dep) begin
      void'(mq.pop_front());
      m_wrap = 1'b1;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   dep = sel ? D1_DEPTH : D0_DEPTH;
    int   pt  = sel ? D1_POST : D0_POST;
    int   md  = sel ? D1_MODE : D0_MODE;
    bit   armv = sel ? arm1 : arm0;
    ent_t e = {cap_pc, cap_opcode, cap_rd, cap_rs1, cap_rs2, cap_imm, cap_reg_write,
               cap_alu_src};
    if (!reset) begin
      m_state = 0; m_wrap = 1'b0; mq.delete();
      return;
    end
    if (abort) begin
      m_state = 0; mq.delete();
      return;
    end
    case (m_state)
      0: if (armv) begin
        mq.delete(); m_wrap = 1'b0;
        if (md == 1) begin
          m_left = pt; m_state = 2;
          if (cap_valid) begin
            push(e, dep);
            if (pt == 0) m_state = 3;
          end
        end else m_state = 1;
      end
      1: if (cap_valid) begin
        push(e, dep);
        if (cap_pc == trig_pc) begin
          m_left = pt; m_state = (pt == 0) ? 3 : 2;
        end
      end
      2: if (cap_valid) begin
        push(e, dep);
        if (m_left <= 1) m_state = 3; else m_left--;
      end
      default: if (mq.size() == 0) m_state = 0;
        else if (rd_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_state = 0;
        end
    endcase
  endtask

  task automatic check_all();
    bit v = (m_state == 3) && (mq.size() != 0);
    chk("state", obs_state, m_state);
    chk("count", obs_count, mq.size());
    chk("wrapped", obs_wrapped, m_wrap);
    chk("rd_valid", obs_valid, v);
    if (v) chk("rd_data", obs_data, mq[0]);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_cap(input logic v, input logic [31:0] pc);
    cap_valid     = v;
    cap_pc        = pc;
    cap_opcode    = 7'($urandom);
    cap_rd        = 5'($urandom);
    cap_rs1       = 5'($urandom);
    cap_rs2       = 5'($urandom);
    cap_imm       = $urandom;
    cap_reg_write = 1'($urandom);
    cap_alu_src   = 1'($urandom);
  endtask

  task automatic do_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input int n, input logic [31:0] first_pc);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, obs_valid, 1'b1);
      chk({tag, "_pc"}, obs_pc, first_pc + 32'(4 * i));
      step();
    end
    rd_ready = 1'b0;
    chk({tag, "_idle"}, obs_state, 2'b00);
  endtask

  initial begin
    logic [31:0] got[$];
    reset = 1'b0; arm0 = 1'b0; arm1 = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    trig_pc = 32'h0; sel = 1'b0;
    set_cap(1'b0, 32'h0);
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("rst_state", obs_state, 2'b00);
      chk("rst_count", obs_count, 5'd0);
      chk("rst_valid", obs_valid, 1'b0);
      chk("rst_data", obs_data, '0);
    end
    reset = 1'b1; sel = 1'b0;
    step();

    // 1: reset in the middle of the post window after a wrap
    trig_pc = 32'h50;
    arm0 = 1'b1; step(); arm0 = 1'b0;
    for (int i = 0; i <= 22; i++) begin set_cap(1'b1, 32'(4 * i)); step(); end
    chk("t1_post", obs_state, 2'b10);
    chk("t1_wrap_pre", obs_wrapped, 1'b1);
    set_cap(1'b0, 32'h0); reset = 1'b0; step(); reset = 1'b1;
    chk("t1_state", obs_state, 2'b00);
    chk("t1_count", obs_count, 5'd0);
    chk("t1_valid", obs_valid, 1'b0);
    chk("t1_wrapped", obs_wrapped, 1'b0);

    // 2: trigger at 0x20, window overflows the buffer
    trig_pc = 32'h20;
    arm0 = 1'b1; step(); arm0 = 1'b0;
    for (int i = 0; i <= 16; i++) begin set_cap(1'b1, 32'(4 * i)); step(); end
    set_cap(1'b0, 32'h0);
    chk("t2_done", obs_state, 2'b11);
    chk("t2_count", obs_count, 5'd16);
    chk("t2_wrapped", obs_wrapped, 1'b1);
    drain_expect("t2", 16, 32'h04);

    // 3: trigger at 0x08, no overflow
    trig_pc = 32'h08;
    arm0 = 1'b1; step(); arm0 = 1'b0;
    for (int i = 0; i <= 10; i++) begin set_cap(1'b1, 32'(4 * i)); step(); end
    set_cap(1'b0, 32'h0);
    chk("t3_done", obs_state, 2'b11);
    chk("t3_count", obs_count, 5'd11);
    chk("t3_wrapped", obs_wrapped, 1'b0);
    drain_expect("t3", 11, 32'h00);

    // 4: trigger on arm, capture every cycle, rd_ready toggling
    sel = 1'b1;
    arm1 = 1'b1;
    for (int k = 0; k < 4; k++) begin set_cap(1'b1, 32'h100 + 32'(4 * k)); step(); arm1 = 1'b0; end
    chk("t4_done", obs_state, 2'b11);
    chk("t4_count", obs_count, 5'd4);
    for (int c = 0; c < 16; c++) begin
      set_cap(1'b1, 32'h200 + 32'(4 * c));
      rd_ready = (c % 2 == 0);
      if (obs_valid && rd_ready) got.push_back(obs_pc);
      step();
    end
    rd_ready = 1'b0;
    chk("t4_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("t4_pc", got[i], 32'h100 + 32'(4 * i));
    chk("t4_idle", obs_state, 2'b00);

    // 5: abort together with arm and capture while in POST
    set_cap(1'b0, 32'h0);
    arm1 = 1'b1; step(); arm1 = 1'b0;
    set_cap(1'b1, 32'h200); step();
    chk("t5_post", obs_state, 2'b10);
    abort = 1'b1; arm1 = 1'b1; set_cap(1'b1, 32'h204); step(); abort = 1'b0;
    chk("t5_state", obs_state, 2'b00);
    chk("t5_count", obs_count, 5'd0);
    for (int k = 0; k < 4; k++) begin set_cap(1'b1, 32'h300 + 32'(4 * k)); step(); arm1 = 1'b0; end
    set_cap(1'b0, 32'h0);
    chk("t5_done", obs_state, 2'b11);
    drain_expect("t5", 4, 32'h300);

    // 6: field packing of the trigger entry
    arm1 = 1'b1;
    set_cap(1'b1, 32'hDEAD_BEE0);
    cap_opcode = 7'b0010011; cap_rd = 5'd5; cap_rs1 = 5'd2; cap_rs2 = 5'd0;
    cap_imm = 32'hFFFF_FFFF; cap_reg_write = 1'b1; cap_alu_src = 1'b1;
    step(); arm1 = 1'b0;
    for (int k = 0; k < 3; k++) begin set_cap(1'b1, 32'h40 + 32'(4 * k)); step(); end
    set_cap(1'b0, 32'h0);
    chk("t6_pc", obs_data[87:56], 32'hDEAD_BEE0);
    chk("t6_opcode", obs_data[55:49], 7'b0010011);
    chk("t6_rd", obs_data[48:44], 5'd5);
    chk("t6_rs1", obs_data[43:39], 5'd2);
    chk("t6_rs2", obs_data[38:34], 5'd0);
    chk("t6_imm", obs_data[33:2], 32'hFFFF_FFFF);
    chk("t6_rw", obs_data[1], 1'b1);
    chk("t6_alu", obs_data[0], 1'b1);
    do_abort();

    // random traffic on each configuration
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      trig_pc = 32'h10;
      do_abort();
      for (int c = 0; c < 1500; c++) begin
        set_cap(($urandom % 4) != 0, 32'(4 * ($urandom % 16)));
        if (sel) arm1 = ($urandom % 8) == 0; else arm0 = ($urandom % 8) == 0;
        abort    = ($urandom % 64) == 0;
        rd_ready = 1'($urandom);
        step();
      end
      arm0 = 1'b0; arm1 = 1'b0; rd_ready = 1'b0;
      set_cap(1'b0, 32'h0);
      do_abort();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
